// File: rtl/gestor_obstaculos_if.sv
// Bundle between the obstacle manager and its surroundings: game control inputs,
// the pattern ROM lookup, and the field/score outputs to the renderer.
interface gestor_obstaculos_if #(
  parameter int N_COLS = 8
) ();
  logic                  start;
  logic                  tick;
  logic [2:0]            hero_row;
  logic [3:0]            tipo_obs;
  logic [6:0]            obstaculo;
  logic [7*N_COLS-1:0]   col_field;
  logic                  colision;
  logic                  game_over;
  logic [15:0]           score;

  // master: the surrounding system (game control, ROM, renderer)
  modport master (
    output start, tick, hero_row, obstaculo,
    input  tipo_obs, col_field, colision, game_over, score
  );

  // slave: the obstacle manager itself
  modport slave (
    input  start, tick, hero_row, obstaculo,
    output tipo_obs, col_field, colision, game_over, score
  );
endinterface

// File: rtl/gestor_obstaculos.sv
// Obstacle manager: picks LFSR-driven obstacle types, scrolls the ROM patterns
// through a column field toward the hero column, scores and detects collisions.
module gestor_obstaculos #(
  parameter int         N_COLS    = 8,
  parameter int         GAP       = 3,
  parameter logic [7:0] LFSR_SEED = 8'hA5
) (
  input  logic                 clk,
  input  logic                 rst_n,
  gestor_obstaculos_if.slave   bus
);

  typedef enum logic [1:0] {IDLE, RUN, HIT} state_t;

  function automatic logic [3:0] mod10(input logic [3:0] v);
    return (v >= 4'd10) ? v - 4'd10 : v;
  endfunction

  // An all-zero LFSR would lock up, so a zero seed is replaced by 1.
  localparam logic [7:0] SEED      = (LFSR_SEED == 8'h00) ? 8'h01 : LFSR_SEED;
  localparam logic [3:0] TIPO_SEED = mod10(SEED[3:0]);
  localparam logic [3:0] GAP_LOAD  = GAP[3:0];

  state_t                     state;
  logic [N_COLS-1:0][6:0]     cols;       // packed so column i sits at bits [7i+6:7i]
  logic [3:0]                 gap_cnt;
  logic [7:0]                 lfsr;
  logic [3:0]                 tipo_q;
  logic                       colision_q;
  logic                       game_over_q;
  logic [15:0]                score_q;

  logic [7:0] lfsr_next;
  logic [7:0] lane_mask;
  logic       hit;

  assign lfsr_next = {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
  // Lane 7 maps onto the zero pad bit, so "no lane" can never collide.
  assign lane_mask = {1'b0, cols[0]};
  assign hit       = (state == RUN) && lane_mask[bus.hero_row];

  // NOTE: every register below is assigned with <= so all of them sample the
  // pre-edge values; blocking assignments here would create ordering races.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      cols        <= '0;
      gap_cnt     <= '0;
      lfsr        <= SEED;
      tipo_q      <= TIPO_SEED;
      colision_q  <= 1'b0;
      game_over_q <= 1'b0;
      score_q     <= '0;
    end else begin
      colision_q <= 1'b0;
      if (bus.start) begin
        // Start wins over any tick or pending hit in the same cycle.
        state       <= RUN;
        cols        <= '0;
        gap_cnt     <= '0;
        lfsr        <= SEED;
        tipo_q      <= TIPO_SEED;
        game_over_q <= 1'b0;
        score_q     <= '0;
      end else begin
        case (state)
          IDLE: ;
          RUN: begin
            if (hit) begin
              state       <= HIT;
              colision_q  <= 1'b1;
              game_over_q <= 1'b1;
            end else if (bus.tick) begin
              if ((cols[0] != 7'd0) && (score_q != 16'hFFFF))
                score_q <= score_q + 16'd1;
              if (gap_cnt == 4'd0) begin
                cols    <= {bus.obstaculo, cols[N_COLS-1:1]};
                gap_cnt <= GAP_LOAD;
                lfsr    <= lfsr_next;
                tipo_q  <= mod10(lfsr_next[3:0]);
              end else begin
                cols    <= {7'd0, cols[N_COLS-1:1]};
                gap_cnt <= gap_cnt - 4'd1;
              end
            end
          end
          HIT: ;
          default: state <= IDLE;
        endcase
      end
    end
  end

  assign bus.tipo_obs  = tipo_q;
  assign bus.col_field = cols;
  assign bus.colision  = colision_q;
  assign bus.game_over = game_over_q;
  assign bus.score     = score_q;

endmodule

// File: tb/tb_gestor_obstaculos.sv
// Bench for gestor_obstaculos: a behavioural field model feeds a scoreboard queue,
// plus a hand-derived vector table and directed multi-cycle sequences.
module tb_gestor_obstaculos;

  localparam int         N    = 8;
  localparam logic [7:0] SEED = 8'hA5;

  logic clk;
  logic rst_n;
  int   checks   = 0;
  int   failures = 0;
  int   step_no  = 0;

  gestor_obstaculos_if #(.N_COLS(N)) bus ();

  gestor_obstaculos #(.N_COLS(N), .GAP(3), .LFSR_SEED(SEED)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [6:0] rom_f(input logic [3:0] t);
    case (t)
      4'd0: return 7'b1100011;
      4'd1: return 7'b0011100;
      4'd2: return 7'b1000001;
      4'd3: return 7'b0110110;
      4'd4: return 7'b0001001;
      4'd5: return 7'b1100000;
      4'd6: return 7'b0000111;
      4'd7: return 7'b1110000;
      4'd8: return 7'b0101010;
      4'd9: return 7'b0010100;
      default: return 7'b0000000;
    endcase
  endfunction

  always_comb bus.obstaculo = rom_f(bus.tipo_obs);

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Behavioural model: mode 0=idle 1=run 2=hit
  logic [6:0] m_col [N];
  int         m_gap;
  logic [7:0] m_lfsr;
  int         m_mode;
  int         m_score;
  logic       m_colp;

  typedef struct {
    logic [7*N-1:0] field;
    logic [3:0]     tipo;
    logic           colision;
    logic           game_over;
    logic [15:0]    score;
  } exp_t;

  exp_t sb[$];

  function automatic logic [7:0] lfsr_adv(input logic [7:0] l);
    return {l[6:0], ^(l & 8'b1011_1000)};
  endfunction

  function automatic logic [3:0] m_tipo();
    return 4'(int'(m_lfsr[3:0]) % 10);
  endfunction

  task automatic model_reset();
    foreach (m_col[i]) m_col[i] = '0;
    m_gap = 0; m_lfsr = SEED; m_mode = 0; m_score = 0; m_colp = 1'b0;
  endtask

  task automatic model_step(input logic s, input logic t, input logic [2:0] h);
    logic       hit;
    logic [6:0] outgoing;
    hit    = (m_mode == 1) && (h != 3'd7) && (m_col[0][h] == 1'b1);
    m_colp = 1'b0;
    if (s) begin
      foreach (m_col[i]) m_col[i] = '0;
      m_gap = 0; m_lfsr = SEED; m_score = 0; m_mode = 1;
    end else if (m_mode == 1) begin
      if (hit) begin
        m_mode = 2;
        m_colp = 1'b1;
      end else if (t) begin
        outgoing = m_col[0];
        for (int i = 0; i < N - 1; i++) m_col[i] = m_col[i+1];
        if (m_gap == 0) begin
          m_col[N-1] = rom_f(m_tipo());
          m_gap      = 3;
          m_lfsr     = lfsr_adv(m_lfsr);
        end else begin
          m_col[N-1] = '0;
          m_gap--;
        end
        if (outgoing != 7'd0 && m_score < 65535) m_score++;
      end
    end
  endtask

  // Drive one cycle, push the model's prediction, pop and compare after the edge.
  task automatic drive(input logic s, input logic t, input logic [2:0] h);
    exp_t e;
    bus.start = s; bus.tick = t; bus.hero_row = h;
    model_step(s, t, h);
    for (int i = 0; i < N; i++) e.field[7*i +: 7] = m_col[i];
    e.tipo      = m_tipo();
    e.colision  = m_colp;
    e.game_over = (m_mode == 2);
    e.score     = 16'(m_score);
    sb.push_back(e);
    @(posedge clk); #1;
    bus.start = 1'b0; bus.tick = 1'b0;
    step_no++;
    if (sb.size() == 0) begin
      checks++; failures++;
      $display("FAIL scoreboard_empty: got 0 entries expected 1 at step %0d", step_no);
    end else begin
      e = sb.pop_front();
      check($sformatf("field@%0d", step_no),     64'(bus.col_field), 64'(e.field));
      check($sformatf("tipo@%0d", step_no),      64'(bus.tipo_obs),  64'(e.tipo));
      check($sformatf("colision@%0d", step_no),  64'(bus.colision),  64'(e.colision));
      check($sformatf("game_over@%0d", step_no), 64'(bus.game_over), 64'(e.game_over));
      check($sformatf("score@%0d", step_no),     64'(bus.score),     64'(e.score));
    end
  endtask

  typedef struct {
    logic       s;
    logic       t;
    logic [2:0] h;
    logic [3:0] tipo;
    logic [6:0] c7;
    logic [6:0] c0;
    logic       colp;
    logic       go;
    logic [15:0] score;
  } vec_t;

  vec_t tbl [13];

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // start, then ticks with hero in lane 6, then a start out of HIT
    tbl[0]  = '{1'b1, 1'b0, 3'd6, 4'd5, 7'b0000000, 7'b0000000, 1'b0, 1'b0, 16'd0};
    tbl[1]  = '{1'b0, 1'b1, 3'd6, 4'd0, 7'b1100000, 7'b0000000, 1'b0, 1'b0, 16'd0};
    tbl[2]  = '{1'b0, 1'b1, 3'd6, 4'd0, 7'b0000000, 7'b0000000, 1'b0, 1'b0, 16'd0};
    tbl[3]  = '{1'b0, 1'b1, 3'd6, 4'd0, 7'b0000000, 7'b0000000, 1'b0, 1'b0, 16'd0};
    tbl[4]  = '{1'b0, 1'b1, 3'd6, 4'd0, 7'b0000000, 7'b0000000, 1'b0, 1'b0, 16'd0};
    tbl[5]  = '{1'b0, 1'b1, 3'd6, 4'd5, 7'b1100011, 7'b0000000, 1'b0, 1'b0, 16'd0};
    tbl[6]  = '{1'b0, 1'b1, 3'd6, 4'd5, 7'b0000000, 7'b0000000, 1'b0, 1'b0, 16'd0};
    tbl[7]  = '{1'b0, 1'b1, 3'd6, 4'd5, 7'b0000000, 7'b0000000, 1'b0, 1'b0, 16'd0};
    tbl[8]  = '{1'b0, 1'b1, 3'd6, 4'd5, 7'b0000000, 7'b1100000, 1'b0, 1'b0, 16'd0};
    tbl[9]  = '{1'b0, 1'b0, 3'd6, 4'd5, 7'b0000000, 7'b1100000, 1'b1, 1'b1, 16'd0};
    tbl[10] = '{1'b0, 1'b1, 3'd6, 4'd5, 7'b0000000, 7'b1100000, 1'b0, 1'b1, 16'd0};
    tbl[11] = '{1'b1, 1'b0, 3'd6, 4'd5, 7'b0000000, 7'b0000000, 1'b0, 1'b0, 16'd0};
    tbl[12] = '{1'b0, 1'b1, 3'd6, 4'd0, 7'b1100000, 7'b0000000, 1'b0, 1'b0, 16'd0};

    bus.start = 1'b0; bus.tick = 1'b0; bus.hero_row = 3'd7;
    model_reset();
    rst_n = 1'b0;
    #12;
    check("reset_tipo",      64'(bus.tipo_obs),  64'd5);
    check("reset_field",     64'(bus.col_field), 64'd0);
    check("reset_score",     64'(bus.score),     64'd0);
    check("reset_game_over", 64'(bus.game_over), 64'd0);
    check("reset_colision",  64'(bus.colision),  64'd0);
    @(negedge clk); rst_n = 1'b1;

    // IDLE ignores tick
    drive(1'b0, 1'b1, 3'd0);
    drive(1'b0, 1'b1, 3'd0);

    // Table vectors
    for (int r = 0; r < 13; r++) begin
      drive(tbl[r].s, tbl[r].t, tbl[r].h);
      check($sformatf("tbl%0d_tipo", r),  64'(bus.tipo_obs),          64'(tbl[r].tipo));
      check($sformatf("tbl%0d_col7", r),  64'(bus.col_field[7*N-1 -: 7]), 64'(tbl[r].c7));
      check($sformatf("tbl%0d_col0", r),  64'(bus.col_field[6:0]),    64'(tbl[r].c0));
      check($sformatf("tbl%0d_colp", r),  64'(bus.colision),          64'(tbl[r].colp));
      check($sformatf("tbl%0d_go", r),    64'(bus.game_over),         64'(tbl[r].go));
      check($sformatf("tbl%0d_score", r), 64'(bus.score),             64'(tbl[r].score));
    end

    // Hero in lane 0: first obstacle passes, second hits after tick 12
    drive(1'b1, 1'b0, 3'd0);
    for (int k = 1; k <= 12; k++) begin
      drive(1'b0, 1'b1, 3'd0);
      if (k == 9) check("laneb_score_t9", 64'(bus.score), 64'd1);
      if (k == 12) begin
        check("laneb_col0_t12", 64'(bus.col_field[6:0]), 64'(7'b1100011));
        check("laneb_nopulse_t12", 64'(bus.colision), 64'd0);
      end
    end
    // hit pending together with a tick: HIT wins, no shift
    drive(1'b0, 1'b1, 3'd0);
    check("laneb_colision", 64'(bus.colision),       64'd1);
    check("laneb_col0_held", 64'(bus.col_field[6:0]), 64'(7'b1100011));
    drive(1'b0, 1'b0, 3'd0);
    check("laneb_pulse_once", 64'(bus.colision), 64'd0);

    // Lane change into a blocked lane without a tick
    drive(1'b1, 1'b0, 3'd7);
    for (int k = 1; k <= 24; k++) drive(1'b0, 1'b1, 3'd7);
    check("lane_col0", 64'(bus.col_field[6:0]), 64'(7'b0001001));
    drive(1'b0, 1'b0, 3'd1);
    check("lane_free", 64'(bus.colision), 64'd0);
    drive(1'b0, 1'b0, 3'd3);
    check("lane_hit", 64'(bus.colision), 64'd1);
    check("lane_go",  64'(bus.game_over), 64'd1);

    // No lane for 40 ticks: obstacles leave column 0 at ticks 9,13,...,37
    drive(1'b1, 1'b0, 3'd7);
    for (int k = 1; k <= 40; k++) drive(1'b0, 1'b1, 3'd7);
    check("nolane_score", 64'(bus.score), 64'd8);
    check("nolane_go",    64'(bus.game_over), 64'd0);

    // start together with tick in RUN
    drive(1'b1, 1'b1, 3'd7);
    check("st_field", 64'(bus.col_field), 64'd0);
    check("st_score", 64'(bus.score),     64'd0);
    check("st_tipo",  64'(bus.tipo_obs),  64'd5);

    // Mid-game asynchronous reset
    for (int k = 1; k <= 10; k++) drive(1'b0, 1'b1, 3'd7);
    #3 rst_n = 1'b0;
    #1;
    check("arst_field", 64'(bus.col_field), 64'd0);
    check("arst_score", 64'(bus.score),     64'd0);
    check("arst_go",    64'(bus.game_over), 64'd0);
    check("arst_tipo",  64'(bus.tipo_obs),  64'd5);
    check("arst_colp",  64'(bus.colision),  64'd0);
    model_reset();
    @(negedge clk); rst_n = 1'b1;
    drive(1'b0, 1'b1, 3'd7);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/gestor_obstaculos.md
Name: gestor_obstaculos

Overview:
- Reader/consumer side of the obstacle pattern ROM.
- Picks pseudo-random obstacle types and drives `tipo_obs` to the ROM. Captures the returned 7-lane pattern into a scrolling column field and detects hero collisions.
- Sits between the game-control FSM (start, tick, hero lane) and the display renderer (column field, score, game_over).

Parameters:
- N_COLS, 8: number of field columns. Column 0 is the hero column; column N_COLS-1 is the entry column. Legal range 2..16.
- GAP, 3: empty columns inserted between consecutive obstacles. Legal range 0..15.
- LFSR_SEED, 8'hA5: LFSR value loaded at reset and on start. 8'h00 is replaced by 8'h01.

Ports:
- clk  in  1  system clock; all state on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle pulse; clears the field and enters RUN.
- tick  in  1  one-cycle pulse; advances the field one column.
- hero_row  in  3  hero lane 0..6. Value 7 means no lane and never collides.
- tipo_obs  out  4  obstacle type 0..9 to the ROM; registered.
- obstaculo  in  7  ROM pattern for tipo_obs, combinational, valid in the same cycle. Bit=1 means the lane is blocked.
- col_field  out  7*N_COLS  column i occupies bits [7i+6:7i]; registered.
- colision  out  1  one-cycle pulse on a detected hit.
- game_over  out  1  high while in HIT.
- score  out  16  obstacles cleared; saturates at 16'hFFFF.

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE, lfsr=seed, tipo_obs=seed[3:0] mod 10, col_field=0, gap_cnt=0.
  - colision=0, game_over=0, score=0.
  - With the default seed, tipo_obs resets to 5.
- LFSR: 8-bit. fb = l[7]^l[5]^l[4]^l[3]; next = {l[6:0], fb}. It advances only on a load tick.
- tipo_obs update: tipo_obs <= next[3:0] mod 10, computed as value-10 when value >= 10. It updates in the same edge as the LFSR advance.
- States:
  - IDLE: tick is ignored; start -> RUN.
  - RUN: tick shifts the field; a collision -> HIT.
  - HIT: game_over=1 and the field is frozen; tick is ignored; start -> RUN.
- Start action (in any state):
  - Clear col_field and score; set gap_cnt=0; reload the LFSR with the seed and tipo_obs with seed[3:0] mod 10.
  - Clear game_over.
- Tick in RUN:
  - col[i] <= col[i+1] for i < N_COLS-1.
  - If gap_cnt==0: col[N_COLS-1] <= obstaculo, gap_cnt <= GAP, and the LFSR/tipo_obs advance.
  - Otherwise: col[N_COLS-1] <= 0 and gap_cnt decrements.
- Collision is evaluated every cycle in RUN on the registered col[0]:
  - A hit is col[0][hero_row]==1 with hero_row<=6.
  - On a hit: the next edge gives state=HIT and colision=1 for exactly one cycle.
  - This catches the hero moving into a blocked lane as well as an obstacle arriving.
  - Latency: the pulse appears on the edge after col[0] or hero_row makes the condition true.
- Score: on a tick in RUN where the outgoing col[0] != 0 and no hit is pending that cycle, score += 1 (saturating).
- Simultaneous events:
  - start with tick: start wins and the tick is dropped.
  - A hit pending with tick: HIT wins; no shift and no score.
  - start while in HIT: RUN, per the start action.
- Reset mid-game: immediate async clear to the reset values above; no pulse is emitted.
- The ROM never returns 7'b1111111, so every obstacle has a free lane. The block does not rely on this.

Test Plan:
- Reset: rst_n=0 asserted mid-RUN -> col_field=0, score=0, game_over=0, tipo_obs=5 asynchronously, before the next edge.
- start, then 8 ticks with hero_row=6 and the bench ROM model:
  - tick 1 loads 7'b1100000 into col[7] and tipo_obs becomes 0.
  - After tick 8, col[0]=7'b1100000, so colision pulses 1 cycle and game_over=1.
  - Further ticks leave col_field unchanged.
- Same as above but hero_row=0:
  - no collision through tick 8; tick 9 gives score=1.
  - The second obstacle (7'b1100011) loads at tick 5 (GAP=3) and reaches col[0] at tick 12.
  - Hero row 0 is blocked, so colision follows tick 12.
- Lane change: with col[0]=7'b0001001 and hero_row=1, change hero_row to 3 (no tick) -> colision on the next edge and state=HIT.
- hero_row=7 held for 40 ticks -> never collides; score increments once per obstacle leaving column 0.
- start asserted with tick in RUN -> field cleared, score=0, no shift, tipo_obs=5; a start in HIT resumes RUN with game_over=0.
